// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: geometry, FSM encodings and
// key-count classification used by the debounce state machine.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEYS     = NUM_ROWS * NUM_COLS;

   typedef enum logic [2:0] {
      ST_REL   = 3'b001,
      ST_PRESS = 3'b010,
      ST_MULTI = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      ONE  = 2'd1,
      MANY = 2'd2
   } pop_t;

   // Clearing the lowest set bit leaves zero only for a single-bit word.
   function automatic pop_t pop_class(input logic [KEYS-1:0] v);
      if (v == '0)
         return ZERO;
      else if ((v & (v - 1'b1)) == '0)
         return ONE;
      else
         return MANY;
   endfunction

endpackage

// File: rtl/keypad_col_timer.sv
// Column dwell timer: holds each column low for SCAN_DIV cycles and strobes
// sample_stb on the last cycle of the dwell, while col_idx still names it.
module keypad_col_timer
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                sample_stb,
   output logic [1:0]          col_idx,
   output logic [NUM_COLS-1:0] col_out
);

   localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

   logic [15:0] cnt;

   assign sample_stb = (cnt == LAST);
   assign col_out    = ~(4'b0001 << col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         col_idx <= 2'd0;
      end else if (sample_stb) begin
         cnt     <= '0;
         col_idx <= col_idx + 2'd1;
      end else begin
         cnt     <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low keypad scanner with full-scan debounce; presents a legal
// one-hot key word (or zero) to the downstream 16-to-4 encoder.
module keypad_scan_4x4
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_out,
   output logic [KEYS-1:0]     key_onehot,
   output logic                key_valid,
   output logic                key_held,
   output logic                key_multi
);

   localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

   logic                sample_stb;
   logic [1:0]          col_idx;
   logic [NUM_ROWS-1:0] row_p0, row_p1;
   logic [NUM_ROWS-1:0] pressed;
   logic [KEYS-1:0]     snap, snap_nxt, prev;
   logic [3:0]          stable, stable_nxt;
   logic                scan_done, deb_upd;
   pop_t                cls;
   state_t              state;

   keypad_col_timer #(.SCAN_DIV(SCAN_DIV)) u_col_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_stb (sample_stb),
      .col_idx    (col_idx),
      .col_out    (col_out)
   );

   // Synchronizer stage: rows idle high, so reset to "nothing pressed"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_p0 <= '1;
         row_p1 <= '1;
      end else begin
         row_p0 <= row_in;
         row_p1 <= row_p0;
      end
   end

   assign pressed = ~row_p1;

   always_comb begin
      snap_nxt = snap;
      for (int r = 0; r < NUM_ROWS; r++)
         snap_nxt[r*NUM_COLS + int'(col_idx)] = pressed[r];
   end

   assign scan_done  = sample_stb && (col_idx == 2'd3);
   assign stable_nxt = (snap_nxt != prev)   ? 4'd1 :
                       (stable == DEB_MAX)  ? DEB_MAX : stable + 4'd1;
   // The completed snapshot doubles as the debounced vector on the update cycle
   assign deb_upd    = scan_done && (stable_nxt == DEB_MAX);
   assign cls        = pop_class(snap_nxt);

   // Snapshot / debounce stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap   <= '0;
         prev   <= '0;
         stable <= '0;
      end else begin
         if (sample_stb)
            snap <= snap_nxt;
         if (scan_done) begin
            prev   <= snap_nxt;
            stable <= stable_nxt;
         end
      end
   end

   // Output stage: FSM and registered key outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_REL;
         key_onehot <= '0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
         key_multi  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (deb_upd) begin
            unique case (state)
               ST_REL, ST_MULTI: begin
                  if (cls == ZERO) begin
                     state      <= ST_REL;
                     key_onehot <= '0;
                     key_held   <= 1'b0;
                     key_multi  <= 1'b0;
                  end else if (cls == ONE) begin
                     state      <= ST_PRESS;
                     key_onehot <= snap_nxt;
                     key_valid  <= 1'b1;
                     key_held   <= 1'b1;
                     key_multi  <= 1'b0;
                  end else begin
                     state      <= ST_MULTI;
                     key_onehot <= '0;
                     key_held   <= 1'b0;
                     key_multi  <= 1'b1;
                  end
               end
               ST_PRESS: begin
                  if (cls == ZERO) begin
                     state      <= ST_REL;
                     key_onehot <= '0;
                     key_held   <= 1'b0;
                  end else if (cls == ONE) begin
                     if (snap_nxt != key_onehot) begin
                        key_onehot <= snap_nxt;
                        key_valid  <= 1'b1;
                     end
                  end else begin
                     state      <= ST_MULTI;
                     key_onehot <= '0;
                     key_held   <= 1'b0;
                     key_multi  <= 1'b1;
                  end
               end
               default: begin
                  state      <= ST_REL;
                  key_onehot <= '0;
                  key_held   <= 1'b0;
                  key_multi  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a physical keypad model drives the rows, and a
// settled-state model derived from the held key set predicts the outputs.
module tb_keypad_scan_4x4;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;
   localparam int SCAN     = 4 * SCAN_DIV;
   localparam int SETTLE   = (DEBOUNCE + 2) * SCAN + 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] key_onehot;
   logic        key_valid, key_held, key_multi;

   logic [15:0] keys = '0;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          dbl = 0;
   logic        last_valid = 1'b0;

   keypad_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row_in     (row_in),
      .col_out    (col_out),
      .key_onehot (key_onehot),
      .key_valid  (key_valid),
      .key_held   (key_held),
      .key_multi  (key_multi)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column while that column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_out[c] && keys[r*4 + c])
               row_in[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulses++;
         if (last_valid) dbl++;
      end
      last_valid = key_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Settled outputs follow from how many keys are held, not from any FSM detail.
   task automatic check_state(input string tag, input logic [15:0] held, input int exp_pulses);
      int n;
      n = $countones(held);
      check({tag, "_onehot"}, key_onehot, (n == 1) ? held : 16'h0);
      check({tag, "_held"},   key_held,   (n == 1) ? 1 : 0);
      check({tag, "_multi"},  key_multi,  (n >= 2) ? 1 : 0);
      check({tag, "_pulses"}, pulses,     exp_pulses);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_pulses();
      @(posedge clk);
      #1 pulses = 0;
   endtask

   initial begin
      logic [3:0] ec;
      int         k, k2;
      int         waited;

      keys  = '0;
      rst_n = 1'b0;
      cycles(3);
      check("rst_col", col_out, 4'hE);
      check("rst_outs", {key_onehot, key_valid, key_held, key_multi}, 0);

      rst_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         ec = 4'hF;
         ec[(i / SCAN_DIV) % 4] = 1'b0;
         check("rot_col", col_out, ec);
         check("rot_outs", {key_onehot, key_valid, key_held, key_multi}, 0);
      end
      cycles(SETTLE);
      clr_pulses();

      // Clean press and release of row1/col1
      keys = 16'h0020;
      cycles(SETTLE);
      check_state("t1_press", keys, 1);
      clr_pulses();
      keys = 16'h0000;
      cycles(SETTLE);
      check_state("t1_rel", keys, 0);

      // Bounce on row2/col3, phased so no two consecutive scans see it pressed
      clr_pulses();
      waited = 0;
      while (col_out != 4'b1011 && waited < 64) begin @(negedge clk); waited++; end
      while (col_out != 4'b0111 && waited < 64) begin @(negedge clk); waited++; end
      check("t2_align_timeout", (waited < 64) ? 1 : 0, 1);
      cycles(8);
      for (int i = 0; i < 40; i++) begin
         keys = (((i / 7) % 2) == 0) ? 16'h0800 : 16'h0000;
         @(negedge clk);
      end
      keys = 16'h0800;
      check("t2_bounce_onehot", key_onehot, 16'h0);
      check("t2_bounce_pulses", pulses, 0);
      cycles(SETTLE);
      check_state("t2_stable", keys, 1);
      keys = 16'h0000;
      cycles(SETTLE);

      // Two keys, then release one of them
      clr_pulses();
      keys = 16'h8001;
      cycles(SETTLE);
      check_state("t3_multi", keys, 0);
      clr_pulses();
      keys = 16'h0001;
      cycles(SETTLE);
      check_state("t3_single", keys, 1);
      keys = 16'h0000;
      cycles(SETTLE);

      // Single-scan glitch on key 7
      clr_pulses();
      keys = 16'h0080;
      cycles(SCAN);
      keys = 16'h0000;
      cycles(SETTLE);
      check_state("t4_glitch", keys, 0);

      // Random single keys, key changes and two-key overlaps
      for (int r = 0; r < 4; r++) begin
         k  = $urandom_range(15, 0);
         k2 = (k + 1 + $urandom_range(14, 0)) % 16;
         clr_pulses();
         keys = 16'h1 << k;
         cycles(SETTLE);
         check_state("rnd_first", keys, 1);
         clr_pulses();
         keys = 16'h1 << k2;
         cycles(SETTLE);
         check_state("rnd_change", keys, 1);
         clr_pulses();
         keys = (16'h1 << k) | (16'h1 << k2);
         cycles(SETTLE);
         check_state("rnd_pair", keys, 0);
         clr_pulses();
         keys = 16'h1 << k;
         cycles(SETTLE);
         check_state("rnd_remain", keys, 1);
         clr_pulses();
         keys = 16'h0000;
         cycles(SETTLE);
         check_state("rnd_rel", keys, 0);
      end

      // Reset mid-scan while key 9 is held
      clr_pulses();
      keys = 16'h0200;
      cycles(SETTLE);
      check_state("t6_held", keys, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_col", col_out, 4'hE);
      check("t6_rst_outs", {key_onehot, key_valid, key_held, key_multi}, 0);
      cycles(3);
      rst_n = 1'b1;
      clr_pulses();
      cycles(SETTLE);
      check_state("t6_after", keys, 1);
      keys = 16'h0000;
      cycles(SETTLE);

      check("valid_width", dbl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Scans a 4x4 active-low matrix keypad and debounces it.
- Emits a debounced 16-bit one-hot key vector with a one-cycle valid pulse for each new single-key press.
- Sits directly upstream of the 16-to-4 encoder: key_onehot feeds its one-hot input unchanged.
- Multi-key and no-key conditions drive key_onehot to zero, so only legal one-hot words reach the encoder.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell); range 2..65535.
- DEBOUNCE, 4: consecutive identical full-scan snapshots required before the debounced state changes; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- row_in  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
- col_out  output  4  column drive; exactly one bit low at a time, the others high.
- key_onehot  output  16  debounced pressed key, bit index = row*4 + col; zero when no key or more than one key.
- key_valid  output  1  one-cycle pulse when key_onehot takes a new non-zero value.
- key_held  output  1  high while key_onehot is non-zero.
- key_multi  output  1  high while the debounced state has two or more keys pressed.

Behaviour:
- Reset (async assert, sync release):
  - col_out=4'b1110 (column 0); all other outputs 0.
  - Dwell counter, snapshot, previous snapshot and stable counter = 0; debounce FSM = REL.
- Input sync: row_in passes through a 2-flop synchronizer before any use. Inverted value = pressed mask.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: sample the synchronized pressed rows into snapshot bits {r*4+col}, then rotate col_out to the next column (3 wraps to 0) and clear the counter.
  - Full scan = 4*SCAN_DIV cycles.
- Scan-complete event: the cycle column 3 is sampled.
  - If new snapshot == previous snapshot: stable count += 1, saturating at DEBOUNCE. Otherwise: stable count = 1.
  - Previous snapshot <= new snapshot.
  - When stable count reaches DEBOUNCE, the snapshot becomes the debounced vector (deb).
- Debounce FSM (evaluated only when deb updates):
  - REL: deb zero. Single bit -> PRESS. Two or more bits -> MULTI.
  - PRESS: deb zero -> REL. Different single bit -> PRESS with a new key. Two or more bits -> MULTI.
  - MULTI: deb zero -> REL. Exactly one bit -> PRESS.
  - States are one-hot encoded.
- Outputs (registered, updated the cycle after the deb update):
  - PRESS: key_onehot=deb, key_held=1, key_multi=0.
  - REL: all 0.
  - MULTI: key_onehot=0, key_held=0, key_multi=1.
  - key_valid pulses for exactly 1 cycle on entry to PRESS, and on a PRESS->PRESS key change. No pulse when the same key remains held.
- Boundary conditions:
  - A key bounce inside the debounce window resets the stable count; no output change results.
  - A press shorter than DEBOUNCE scans is ignored entirely.
  - MULTI->PRESS (e.g. releasing one of two keys) pulses key_valid for the remaining key.
  - Reset mid-scan returns to column 0 immediately. Any pending pulse is dropped.
- Latency: a clean press is reported DEBOUNCE to DEBOUNCE+1 full scans after it, plus 3 cycles (2 sync + 1 output).

Decomposition:
- Shared constant package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4, KEYS=16.
  - FSM state encodings ST_REL, ST_PRESS, ST_MULTI.
  - Popcount-class constants ZERO/ONE/MANY.
- One sub-module: keypad_col_timer, the dwell counter plus rotating column drive. It emits sample_stb and col_idx[1:0].
- The rest (sync, snapshot, debounce, FSM) stays in the top.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE=2; full scan = 16 cycles):
- Reset held, then released: col_out=1110, rotates 1101, 1011, 0111, 1110 every 4 cycles; all key outputs 0 throughout.
- Model presses row1/col1 and holds: within 3 scans + 3 cycles key_onehot=16'h0020, key_held=1, key_valid high exactly 1 cycle; on release, all 0 after debounce with no pulse.
- Row2/col3 press bouncing (toggles every 7 cycles for 40 cycles), then stable: no output during the bounce; one valid pulse with key_onehot=16'h0800 only after stable.
- Keys 0 and 15 pressed together: key_multi=1, key_onehot=0, no pulse; release key 15 -> key_onehot=16'h0001 with one pulse, key_multi=0.
- 1-scan glitch on key 7: no change on any output.
- rst_n asserted mid-scan while key 9 is held: outputs 0 and col_out=1110 asynchronously; after release of reset, key 9 is re-reported with one pulse, 16'h0200.
